// File: rtl/multiplier_clock_gen.sv
// rtl/multiplier_clock_gen.sv - divided clocks Clk200/Clk400 and delayed enable En for the Booth controller (optional ticks: CLKGEN_TICK_EN)
module multiplier_clock_gen #(
   parameter int DIV_FAST = 2,
   parameter int DIV_SLOW = 4,
   parameter int EN_DELAY = 3,
   parameter int CNT_W    = 8
) (
   input  logic Clk,
   input  logic Reset,
`ifdef CLKGEN_TICK_EN
   output logic Tick200,
   output logic Tick400,
`endif
   output logic En,
   output logic Clk200,
   output logic Clk400
);

   // Terminal counts of the half-period counters and of the enable delay counter
   localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(DIV_FAST / 2 - 1);
   localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(DIV_SLOW / 2 - 1);
   localparam logic [CNT_W-1:0] EN_TC   = CNT_W'(EN_DELAY - 1);

   // Reject parameter sets that cannot give a 50% duty or a nonzero enable delay
   if ((DIV_FAST < 2) || (DIV_FAST % 2 != 0)) begin : g_bad_fast
      $error("multiplier_clock_gen: DIV_FAST must be even and >= 2");
   end
   if ((DIV_SLOW < 2) || (DIV_SLOW % 2 != 0) || (DIV_SLOW % DIV_FAST != 0)) begin : g_bad_slow
      $error("multiplier_clock_gen: DIV_SLOW must be even and a multiple of DIV_FAST");
   end
   if (EN_DELAY < 1) begin : g_bad_en
      $error("multiplier_clock_gen: EN_DELAY must be >= 1");
   end
   if (((DIV_SLOW / 2) >= (2 ** CNT_W)) || (EN_DELAY >= (2 ** CNT_W))) begin : g_bad_w
      $error("multiplier_clock_gen: CNT_W too narrow for DIV_SLOW/2 or EN_DELAY");
   end

   logic [CNT_W-1:0] r_fast_cnt;
   logic [CNT_W-1:0] r_slow_cnt;
   logic [CNT_W-1:0] r_en_cnt;
   logic             r_clk200;
   logic             r_clk400;
   logic             r_en;
   logic             w_fast_tc;
   logic             w_slow_tc;

   assign w_fast_tc = (r_fast_cnt == FAST_TC);
   assign w_slow_tc = (r_slow_cnt == SLOW_TC);

   // Fast divider: toggle Clk200 every DIV_FAST/2 base edges
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_fast_cnt <= '0;
         r_clk200   <= 1'b0;
      end else if (w_fast_tc) begin
         r_fast_cnt <= '0;
         r_clk200   <= ~r_clk200;
      end else begin
         r_fast_cnt <= r_fast_cnt + CNT_W'(1);
      end
   end

   // Slow divider: toggle Clk400 every DIV_SLOW/2 base edges, phase fixed by reset release
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_slow_cnt <= '0;
         r_clk400   <= 1'b0;
      end else if (w_slow_tc) begin
         r_slow_cnt <= '0;
         r_clk400   <= ~r_clk400;
      end else begin
         r_slow_cnt <= r_slow_cnt + CNT_W'(1);
      end
   end

   // Enable delay: count edges until EN_DELAY, then latch En high and freeze the counter
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_en_cnt <= '0;
         r_en     <= 1'b0;
      end else if (!r_en) begin
         r_en_cnt <= r_en_cnt + CNT_W'(1);
         if (r_en_cnt == EN_TC) begin
            r_en <= 1'b1;
         end
      end
   end

   assign En     = r_en;
   assign Clk200 = r_clk200;
   assign Clk400 = r_clk400;

`ifdef CLKGEN_TICK_EN
   logic r_tick200;
   logic r_tick400;

   // Rising-edge ticks: registered on the same edge the divided clock goes 0->1
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_tick200 <= 1'b0;
         r_tick400 <= 1'b0;
      end else begin
         r_tick200 <= w_fast_tc && !r_clk200;
         r_tick400 <= w_slow_tc && !r_clk400;
      end
   end

   assign Tick200 = r_tick200;
   assign Tick400 = r_tick400;
`endif

endmodule

// File: tb/tb_multiplier_clock_gen.sv
// tb/tb_multiplier_clock_gen.sv - self-checking bench for multiplier_clock_gen (defaults and 4/8 dividers)
module tb_multiplier_clock_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_a, c200_a, c400_a;
   logic en_b, c200_b, c400_b;
`ifdef CLKGEN_TICK_EN
   logic t200_a, t400_a, t200_b, t400_b;
`endif

   int n_cmp  = 0;
   int n_err  = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   multiplier_clock_gen u_dut_a (
      .Clk     (clk),
      .Reset   (rst),
`ifdef CLKGEN_TICK_EN
      .Tick200 (t200_a),
      .Tick400 (t400_a),
`endif
      .En      (en_a),
      .Clk200  (c200_a),
      .Clk400  (c400_a)
   );

   multiplier_clock_gen #(.DIV_FAST(4), .DIV_SLOW(8), .EN_DELAY(5), .CNT_W(8)) u_dut_b (
      .Clk     (clk),
      .Reset   (rst),
`ifdef CLKGEN_TICK_EN
      .Tick200 (t200_b),
      .Tick400 (t400_b),
`endif
      .En      (en_b),
      .Clk200  (c200_b),
      .Clk400  (c400_b)
   );

   typedef struct {
      int edge_no;
      bit en_a, c200_a, c400_a;
      bit c200_b, c400_b;
   } vec_t;

   // Reference: a divided clock of period div is high during the second half of each period
   function automatic bit ref_clk(input int n, input int div);
      if (n <= 0) return 1'b0;
      return ((n / (div / 2)) % 2) == 1;
   endfunction

   function automatic bit ref_tick(input int n, input int div);
      return ref_clk(n, div) && !ref_clk(n - 1, div);
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s edge=%0d actual=%b required=%b", name, edge_n, act, exp);
      end
   endtask

   task automatic check_model();
      chk("en_a",   en_a,   edge_n >= 3);
      chk("c200_a", c200_a, ref_clk(edge_n, 2));
      chk("c400_a", c400_a, ref_clk(edge_n, 4));
      chk("en_b",   en_b,   edge_n >= 5);
      chk("c200_b", c200_b, ref_clk(edge_n, 4));
      chk("c400_b", c400_b, ref_clk(edge_n, 8));
`ifdef CLKGEN_TICK_EN
      chk("t200_a", t200_a, ref_tick(edge_n, 2));
      chk("t400_a", t400_a, ref_tick(edge_n, 4));
      chk("t200_b", t200_b, ref_tick(edge_n, 4));
      chk("t400_b", t400_b, ref_tick(edge_n, 8));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) edge_n++;
      @(negedge clk);
      check_model();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_en_a"},   en_a,   1'b0);
      chk({tag, "_c200_a"}, c200_a, 1'b0);
      chk({tag, "_c400_a"}, c400_a, 1'b0);
      chk({tag, "_en_b"},   en_b,   1'b0);
      chk({tag, "_c200_b"}, c200_b, 1'b0);
      chk({tag, "_c400_b"}, c400_b, 1'b0);
`ifdef CLKGEN_TICK_EN
      chk({tag, "_t200_a"}, t200_a, 1'b0);
      chk({tag, "_t400_a"}, t400_a, 1'b0);
`endif
   endtask

   initial begin
      vec_t vecs[8];
      int   cnt200;
      int   cnt400;

      vecs[0] = '{1, 0, 1, 0, 0, 0};
      vecs[1] = '{2, 0, 0, 1, 1, 0};
      vecs[2] = '{3, 1, 1, 1, 1, 0};
      vecs[3] = '{4, 1, 0, 0, 0, 1};
      vecs[4] = '{5, 1, 1, 0, 0, 1};
      vecs[5] = '{6, 1, 0, 1, 1, 1};
      vecs[6] = '{7, 1, 1, 1, 1, 1};
      vecs[7] = '{8, 1, 0, 0, 0, 0};

      // Reset held three cycles, outputs low throughout
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_zero("rst_hold");
      end
      rst    = 1'b0;
      edge_n = 0;

      // Table of hand-derived values for the first eight edges
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         edge_n++;
         @(negedge clk);
         chk("tbl_edge",   (edge_n == vecs[i].edge_no), 1'b1);
         chk("tbl_en_a",   en_a,   vecs[i].en_a);
         chk("tbl_c200_a", c200_a, vecs[i].c200_a);
         chk("tbl_c400_a", c400_a, vecs[i].c400_a);
         chk("tbl_c200_b", c200_b, vecs[i].c200_b);
         chk("tbl_c400_b", c400_b, vecs[i].c400_b);
      end

      // Continue to edge 16 against the model
      while (edge_n < 16) step();

      // Async reset pulses at random points, each followed by a random run
      for (int r = 0; r < 8; r++) begin
         cnt200 = 0;
         cnt400 = 0;
         @(negedge clk);
         #($urandom_range(1, 3));
         rst = 1'b1;
         #1;
         check_zero("async_rst");
         repeat ($urandom_range(1, 3)) @(posedge clk);
         @(negedge clk);
         check_zero("rst_held");
         rst    = 1'b0;
         edge_n = 0;
         for (int k = 0; k < 16; k++) begin
            step();
`ifdef CLKGEN_TICK_EN
            cnt200 += int'(t200_a);
            cnt400 += int'(t400_a);
`endif
         end
`ifdef CLKGEN_TICK_EN
         chk("tick_ratio", (cnt200 == 8) && (cnt400 == 4), 1'b1);
`endif
         repeat ($urandom_range(0, 20)) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
